// File: rtl/hazard_controller_pkg.sv
// Shared pipeline definitions: controller state encoding and register-0 constant.
package hazard_controller_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MUL_BUSY = 2'b01,
    HALTED   = 2'b10
  } hazState_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline <-> hazard controller signal bundle; master is the pipeline, slave the controller.
interface hazard_controller_if;
  logic [4:0]  IdRs;
  logic [4:0]  IdRt;
  logic        IdUsesRt;
  logic        IdMul;
  logic        IdHalt;
  logic [4:0]  ExRt;
  logic        ExMemRead;
  logic        BranchTaken;
  logic        Resume;
  logic        ClrStats;
  logic        PcWrite;
  logic        IfIdWrite;
  logic        IdExWrite;
  logic        IfIdFlush;
  logic        IdExBubble;
  logic        ExMemBubble;
  logic        MulBusy;
  logic        Halted;
  logic [15:0] StallCount;

  modport master (
    output IdRs, IdRt, IdUsesRt, IdMul, IdHalt, ExRt, ExMemRead,
           BranchTaken, Resume, ClrStats,
    input  PcWrite, IfIdWrite, IdExWrite, IfIdFlush, IdExBubble,
           ExMemBubble, MulBusy, Halted, StallCount
  );

  modport slave (
    input  IdRs, IdRt, IdUsesRt, IdMul, IdHalt, ExRt, ExMemRead,
           BranchTaken, Resume, ClrStats,
    output PcWrite, IfIdWrite, IdExWrite, IfIdFlush, IdExBubble,
           ExMemBubble, MulBusy, Halted, StallCount
  );
endinterface

// File: rtl/hazard_controller_hazard_detect.sv
// Combinational load-use compare between the load in EX and the instruction in ID.
module hazard_detect
  import hazard_controller_pkg::*;
(
  input  logic       ExMemRead,
  input  logic [4:0] ExRt,
  input  logic [4:0] IdRs,
  input  logic [4:0] IdRt,
  input  logic       IdUsesRt,
  output logic       LoadUse
);
  always_comb begin
    LoadUse = ExMemRead && (ExRt != REG_ZERO) &&
              ((ExRt == IdRs) || ((ExRt == IdRt) && IdUsesRt));
  end
endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: branch flush, load-use stall, multi-cycle multiply hold,
// halt/resume, and a saturating stall-cycle counter.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4
) (
  input logic                clk,
  input logic                rst_n,
  hazard_controller_if.slave bus
);

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  hazState_t   state, stateNext;
  logic [3:0]  mulCnt, mulCntNext;
  logic [15:0] stallCnt;
  logic        loadUse;
  logic        pcWrite, ifIdWrite, idExWrite;
  logic        ifIdFlush, idExBubble, exMemBubble;
  logic        stallInc;

  hazard_detect uDetect (
    .ExMemRead (bus.ExMemRead),
    .ExRt      (bus.ExRt),
    .IdRs      (bus.IdRs),
    .IdRt      (bus.IdRt),
    .IdUsesRt  (bus.IdUsesRt),
    .LoadUse   (loadUse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      mulCnt <= '0;
    end else begin
      state  <= stateNext;
      mulCnt <= mulCntNext;
    end
  end

  always_comb begin
    stateNext   = state;
    mulCntNext  = mulCnt;
    pcWrite     = 1'b1;
    ifIdWrite   = 1'b1;
    idExWrite   = 1'b1;
    ifIdFlush   = 1'b0;
    idExBubble  = 1'b0;
    exMemBubble = 1'b0;
    case (state)
      RUN: begin
        // The squashed ID instruction must not start a stall, halt or multiply.
        if (bus.BranchTaken) begin
          ifIdFlush  = 1'b1;
          idExBubble = 1'b1;
        end else if (loadUse) begin
          pcWrite    = 1'b0;
          ifIdWrite  = 1'b0;
          idExBubble = 1'b1;
        end else if (bus.IdHalt) begin
          pcWrite    = 1'b0;
          ifIdWrite  = 1'b0;
          idExBubble = 1'b1;
          stateNext  = HALTED;
        end else if (bus.IdMul) begin
          mulCntNext = MUL_LOAD;
          stateNext  = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        pcWrite     = 1'b0;
        ifIdWrite   = 1'b0;
        idExWrite   = 1'b0;
        exMemBubble = 1'b1;
        mulCntNext  = mulCnt - 4'd1;
        if (mulCnt == 4'd1) stateNext = RUN;
      end
      HALTED: begin
        pcWrite    = 1'b0;
        ifIdWrite  = 1'b0;
        idExBubble = 1'b1;
        if (bus.Resume) stateNext = RUN;
      end
      default: stateNext = RUN;
    endcase
  end

  assign stallInc = (state != HALTED) && !pcWrite;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                stallCnt <= '0;
    else if (bus.ClrStats)     stallCnt <= '0;
    else if (stallInc && (stallCnt != '1)) stallCnt <= stallCnt + 16'd1;
  end

  assign bus.PcWrite     = pcWrite;
  assign bus.IfIdWrite   = ifIdWrite;
  assign bus.IdExWrite   = idExWrite;
  assign bus.IfIdFlush   = ifIdFlush;
  assign bus.IdExBubble  = idExBubble;
  assign bus.ExMemBubble = exMemBubble;
  assign bus.MulBusy     = (state == MUL_BUSY);
  assign bus.Halted      = (state == HALTED);
  assign bus.StallCount  = stallCnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller with hand-computed expectations.
module tb_hazard_controller;
  logic clk;
  logic rst_n;
  int unsigned nChecks;
  int unsigned nPass;

  hazard_controller_if bus ();

  hazard_controller #(.MUL_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input int unsigned got, input int unsigned exp);
    nChecks++;
    if (got == exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.IdRs = '0; bus.IdRt = '0; bus.IdUsesRt = 1'b0; bus.IdMul = 1'b0;
    bus.IdHalt = 1'b0; bus.ExRt = '0; bus.ExMemRead = 1'b0;
    bus.BranchTaken = 1'b0; bus.Resume = 1'b0; bus.ClrStats = 1'b0;
  endtask

  task automatic loadUse(input logic [4:0] r);
    bus.ExMemRead = 1'b1; bus.ExRt = r; bus.IdRs = r;
  endtask

  initial begin
    nChecks = 0;
    nPass   = 0;
    idle();
    rst_n = 1'b0;
    #3;
    checkEq("rst_pc", bus.PcWrite, 1);
    checkEq("rst_ifid", bus.IfIdWrite, 1);
    checkEq("rst_idex", bus.IdExWrite, 1);
    checkEq("rst_bubbles", {bus.IfIdFlush, bus.IdExBubble, bus.ExMemBubble}, 0);
    checkEq("rst_flags", {bus.Halted, bus.MulBusy}, 0);
    checkEq("rst_cnt", bus.StallCount, 0);
    #4 rst_n = 1'b1;
    tick();

    // Single load-use stall
    loadUse(5'd5);
    #1;
    checkEq("lu_pc", bus.PcWrite, 0);
    checkEq("lu_ifid", bus.IfIdWrite, 0);
    checkEq("lu_bubble", bus.IdExBubble, 1);
    checkEq("lu_cnt_before", bus.StallCount, 0);
    tick();
    idle();
    #1;
    checkEq("lu_cnt_after", bus.StallCount, 1);
    checkEq("lu_next_pc", bus.PcWrite, 1);
    checkEq("lu_next_bubble", bus.IdExBubble, 0);

    // Non-hazards: r0 destination, Rt not used; then Rt used
    loadUse(5'd0);
    #1;
    checkEq("lu_r0_pc", bus.PcWrite, 1);
    bus.ExRt = 5'd7; bus.IdRs = 5'd3; bus.IdRt = 5'd7; bus.IdUsesRt = 1'b0;
    #1;
    checkEq("lu_rt_unused_pc", bus.PcWrite, 1);
    bus.IdUsesRt = 1'b1;
    #1;
    checkEq("lu_rt_used_pc", bus.PcWrite, 0);
    tick();
    idle();
    #1;
    checkEq("lu_rt_cnt", bus.StallCount, 2);

    // Multiply: 3 busy cycles
    bus.IdMul = 1'b1;
    #1;
    checkEq("mul_issue_pc", bus.PcWrite, 1);
    checkEq("mul_issue_busy", bus.MulBusy, 0);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      checkEq($sformatf("mul_busy%0d", i), bus.MulBusy, 1);
      checkEq($sformatf("mul_exmem%0d", i), bus.ExMemBubble, 1);
      checkEq($sformatf("mul_idex%0d", i), bus.IdExWrite, 0);
      tick();
    end
    checkEq("mul_done_busy", bus.MulBusy, 0);
    checkEq("mul_done_pc", bus.PcWrite, 1);
    checkEq("mul_cnt", bus.StallCount, 5);

    // Branch beats load-use and multiply
    bus.BranchTaken = 1'b1; bus.IdMul = 1'b1;
    loadUse(5'd5);
    #1;
    checkEq("br_flush", bus.IfIdFlush, 1);
    checkEq("br_bubble", bus.IdExBubble, 1);
    checkEq("br_pc", bus.PcWrite, 1);
    tick();
    idle();
    #1;
    checkEq("br_state_busy", bus.MulBusy, 0);
    checkEq("br_cnt", bus.StallCount, 5);

    // Halt for 10 cycles, then resume
    bus.IdHalt = 1'b1;
    #1;
    checkEq("halt_issue_pc", bus.PcWrite, 0);
    checkEq("halt_issue_bubble", bus.IdExBubble, 1);
    tick();
    idle();
    checkEq("halt_entry_cnt", bus.StallCount, 6);
    for (int i = 0; i < 10; i++) begin
      checkEq($sformatf("halted%0d", i), bus.Halted, 1);
      checkEq($sformatf("halt_pc%0d", i), bus.PcWrite, 0);
      tick();
    end
    checkEq("halt_cnt_const", bus.StallCount, 6);
    bus.Resume = 1'b1;
    #1;
    checkEq("resume_same_cycle", bus.Halted, 1);
    tick();
    idle();
    checkEq("resume_halted", bus.Halted, 0);
    checkEq("resume_pc", bus.PcWrite, 1);

    // Async reset mid-multiply
    bus.IdMul = 1'b1;
    tick();
    idle();
    checkEq("rmul_busy", bus.MulBusy, 1);
    checkEq("rmul_cnt_pre", bus.StallCount, 6);
    #2 rst_n = 1'b0;
    #1;
    checkEq("rmul_busy_rst", bus.MulBusy, 0);
    checkEq("rmul_cnt_rst", bus.StallCount, 0);
    checkEq("rmul_pc_rst", bus.PcWrite, 1);
    checkEq("rmul_exmem_rst", bus.ExMemBubble, 0);
    rst_n = 1'b1;
    tick();

    // Load-use outranks halt; ClrStats wins over an increment
    loadUse(5'd9);
    bus.IdHalt = 1'b1;
    tick();
    checkEq("lu_over_halt", bus.Halted, 0);
    bus.IdHalt = 1'b0;
    tick();
    checkEq("clr_pre", bus.StallCount, 2);
    bus.ClrStats = 1'b1;
    tick();
    checkEq("clr_during_stall", bus.StallCount, 0);
    bus.ClrStats = 1'b0;

    // Saturation: 65534 load-use stalls, then a multiply
    for (int i = 0; i < 65534; i++) tick();
    idle();
    checkEq("sat_pre", bus.StallCount, 16'hFFFE);
    bus.IdMul = 1'b1;
    tick();
    idle();
    tick();
    checkEq("sat_first", bus.StallCount, 16'hFFFF);
    tick();
    tick();
    checkEq("sat_hold", bus.StallCount, 16'hFFFF);
    checkEq("sat_run", bus.MulBusy, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
